// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first frames with optional parity and 1-2 stop bits.
// sdata is registered from the current state, so the line trails the FSM by one clock.
module uart_tx_fifo #(
    parameter int BYTESIZES           = 8,
    parameter int BAUDRATE            = 9600,
    parameter int COUNTER_CLOCK_INPUT = 50_000_000,
    parameter int FIFO_DEPTH          = 8,
    parameter int PARITY              = 0,
    parameter int STOP_BITS           = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              valid,
    input  logic [BYTESIZES-1:0]              data,
    output logic                              ready,
    output logic                              sdata,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int DIV = COUNTER_CLOCK_INPUT / BAUDRATE;
    localparam int BW  = $clog2(DIV);
    localparam int NW  = $clog2(BYTESIZES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [NW-1:0]        bit_q, bit_d;
    logic [BYTESIZES-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 sdata_q, sdata_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BYTESIZES-1:0] mem_q [FIFO_DEPTH];
    logic                 push, pop, bit_end, head_par;
    logic [BYTESIZES-1:0] head;

    assign ready      = (count_q < CW'(FIFO_DEPTH)) & ~reset;
    assign push       = valid & ready;
    assign head       = mem_q[rd_q];
    assign head_par   = (PARITY == 2) ? ~^head : ^head;
    assign bit_end    = baud_q == BW'(DIV - 1);
    assign sdata      = sdata_q;
    assign busy       = state_q != S_IDLE;
    assign fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                pop    = count_q != '0;
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == NW'(BYTESIZES - 1)) begin
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    bit_d   = '0;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: if (bit_end) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == NW'(STOP_BITS - 1)) begin
                    pop     = count_q != '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a pop always launches a new frame, from IDLE or straight out of the last stop bit
        if (pop) begin
            state_d = S_START;
            shift_d = head;
            par_d   = head_par;
            bit_d   = '0;
        end
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        sdata_d = (state_q == S_START) ? 1'b0 :
                  (state_q == S_DATA) ? shift_q[0] :
                  (state_q == S_PARITY) ? par_q : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            sdata_q <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            sdata_q <= sdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
        if (push) mem_q[wr_q] <= data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four DUT configurations (none/even/odd parity, two stop bits) with DIV=16;
// a frame monitor pops expected words from a scoreboard queue and checks every line cycle.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       vld [4];
    logic [7:0] din [4];
    logic       rdy [4];
    logic       sd  [4];
    logic       bsy [4];
    logic [3:0] cnt [4];

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int busy_cnt [4] = '{0, 0, 0, 0};
    int pm_tab [4] = '{0, 1, 2, 1};
    int sb_tab [4] = '{1, 1, 1, 2};
    logic [7:0] exp_q [$];

    int msel = 0;
    logic mon_en = 1'b0;
    int fcyc = -1;
    int nb, fb;
    int frames_done = 0;
    int start_tick = 0;
    int last_end_tick = 0;
    logic [15:0] fbits;
    logic [7:0] cur;
    logic fobs;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(1), .COUNTER_CLOCK_INPUT(16), .FIFO_DEPTH(8), .PARITY(0), .STOP_BITS(1))
        u0 (.clock(clk), .reset(rst), .valid(vld[0]), .data(din[0]), .ready(rdy[0]), .sdata(sd[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(1), .COUNTER_CLOCK_INPUT(16), .FIFO_DEPTH(8), .PARITY(1), .STOP_BITS(1))
        u1 (.clock(clk), .reset(rst), .valid(vld[1]), .data(din[1]), .ready(rdy[1]), .sdata(sd[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(1), .COUNTER_CLOCK_INPUT(16), .FIFO_DEPTH(8), .PARITY(2), .STOP_BITS(1))
        u2 (.clock(clk), .reset(rst), .valid(vld[2]), .data(din[2]), .ready(rdy[2]), .sdata(sd[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(1), .COUNTER_CLOCK_INPUT(16), .FIFO_DEPTH(8), .PARITY(1), .STOP_BITS(2))
        u3 (.clock(clk), .reset(rst), .valid(vld[3]), .data(din[3]), .ready(rdy[3]), .sdata(sd[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

    always @(posedge clk) begin
        tick++;
        for (int i = 0; i < 4; i++) if (bsy[i]) busy_cnt[i]++;
    end

    always @(negedge clk) begin
        if (!mon_en) fcyc = -1;
        else begin
            if (fcyc < 0 && sd[msel] === 1'b0) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_frame: observed start bit on line %0d, expected none queued", msel);
                end
                cur = 8'h00;
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                fbits = '1;
                fbits[0] = 1'b0;
                for (int i = 0; i < 8; i++) fbits[i+1] = cur[i];
                nb = 9 + sb_tab[msel];
                if (pm_tab[msel] != 0) begin
                    fbits[9] = (pm_tab[msel] == 1) ? ^cur : ~^cur;
                    nb++;
                end
                fcyc = 0;
                start_tick = tick;
            end
            if (fcyc >= 0) begin
                fb = fcyc / 16;
                if (fcyc % 16 == 0) fobs = fbits[fb];
                if (sd[msel] !== fbits[fb]) fobs = sd[msel];
                if (fcyc % 16 == 15) begin
                    checks++;
                    assert (fobs === fbits[fb]) else begin
                        errors++;
                        $error("FAIL frame_bit: word %0h bit %0d observed %0b expected %0b", cur, fb, fobs, fbits[fb]);
                    end
                end
                fcyc++;
                if (fcyc == nb * 16) begin
                    fcyc = -1;
                    frames_done++;
                    last_end_tick = tick;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [7:0] w);
        vld[s] = 1'b1;
        din[s] = w;
        exp_q.push_back(w);
        @(negedge clk);
        vld[s] = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int target);
        int lim = 0;
        while (frames_done < target && lim < 5000) begin
            @(negedge clk);
            lim++;
        end
        chk(tag, frames_done, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, b0, base, s0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            din[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy[0], 0);
        chk("rst_sdata", sd[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_count", cnt[0], 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_ready", rdy[0], 1);

        msel = 0;
        b0 = busy_cnt[0];
        send(0, 8'h55);
        t0 = tick;
        chk("t1_count_push", cnt[0], 1);
        chk("t1_sdata_k", sd[0], 1);
        @(negedge clk);
        chk("t1_busy_k1", bsy[0], 1);
        chk("t1_sdata_k1", sd[0], 1);
        chk("t1_count_pop", cnt[0], 0);
        wait_frames("t1_frame", 1);
        chk("t1_start_lat", start_tick, t0 + 2);
        repeat (2) @(negedge clk);
        chk("t1_busy_len", busy_cnt[0] - b0, 160);
        chk("t1_idle_sdata", sd[0], 1);

        msel = 1;
        b0 = busy_cnt[1];
        send(1, 8'h07);
        wait_frames("t2_even07", 2);
        @(negedge clk);
        chk("t2_busy_len", busy_cnt[1] - b0, 176);
        msel = 2;
        send(2, 8'h07);
        wait_frames("t2_odd07", 3);
        msel = 1;
        send(1, 8'h00);
        wait_frames("t2_even00", 4);

        msel = 0;
        base = frames_done;
        for (int i = 0; i < 10; i++) begin
            vld[0] = 1'b1;
            din[0] = 8'(i);
            if (i < 9) exp_q.push_back(8'(i));
            @(negedge clk);
            chk("t3_ready", rdy[0], (i < 8) ? 1 : 0);
            chk("t3_count", cnt[0], (i == 0) ? 1 : (i > 8) ? 8 : i);
        end
        vld[0] = 1'b0;
        s0 = start_tick;
        wait_frames("t3_frames", base + 9);
        chk("t3_b2b_span", last_end_tick - s0, 9 * 160 - 1);
        repeat (2) @(negedge clk);
        chk("t3_drained", cnt[0], 0);
        chk("t3_idle_busy", bsy[0], 0);

        msel = 3;
        b0 = busy_cnt[3];
        send(3, 8'hFF);
        wait_frames("t4_frame", base + 10);
        @(negedge clk);
        chk("t4_busy_len", busy_cnt[3] - b0, 192);
        chk("t4_idle_sdata", sd[3], 1);

        msel = 0;
        exp_q.push_back(8'hA5);
        vld[0] = 1'b1;
        din[0] = 8'hA5;
        @(negedge clk);
        din[0] = 8'h3C;
        @(negedge clk);
        din[0] = 8'h0F;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("t5_count", cnt[0], 2);
        repeat (69) @(negedge clk);
        chk("t5_bit3", sd[0], 0);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", rdy[0], 0);
        @(negedge clk);
        chk("t5_rst_sdata", sd[0], 1);
        chk("t5_rst_count", cnt[0], 0);
        chk("t5_rst_busy", bsy[0], 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        base = frames_done;
        b0 = busy_cnt[0];
        repeat (400) @(negedge clk);
        chk("t5_no_frames", frames_done, base);
        chk("t5_no_busy", busy_cnt[0] - b0, 0);
        chk("t5_sdata_idle", sd[0], 1);

        for (int i = 0; i < 9; i++) begin
            vld[0] = 1'b1;
            din[0] = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        chk("t6_full", cnt[0], 8);
        din[0] = 8'h99;
        repeat (153) @(negedge clk);
        chk("t6_full_pop_count", cnt[0], 7);
        chk("t6_ready_after", rdy[0], 1);
        vld[0] = 1'b0;
        repeat (159) @(negedge clk);
        chk("t6_count_before", cnt[0], 7);
        send(0, 8'h77);
        chk("t6_pushpop_count", cnt[0], 7);
        wait_frames("t6_frames", base + 10);
        repeat (2) @(negedge clk);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_final_count", cnt[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
